// File: rtl/hilo_muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning the HI/LO register pair.
// One multiply or divide bit per cycle; MTHI/MTLO write HI/LO immediately.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W = (2 * WIDTH)'(1);

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               dz_pend;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;

    logic               accept_arith;
    logic               signed_op;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + ONE_W;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + ONE_2W;
    endfunction

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? neg_w(v) : v;
    endfunction

    assign accept_arith = (state == IDLE) && start && (op[2] == 1'b0);
    assign signed_op    = ~op[0];

    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};
        mul_next = {mul_sum, acc[WIDTH-1:1]};
        // Restoring step: a borrow out of the (WIDTH+1)-bit subtract means keep the shifted remainder.
        rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff = rem_sh - {1'b0, opb};
        div_next = div_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                   : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        prod_fix = neg_res ? neg_2w(acc) : acc;
        quo_fix  = neg_res ? neg_w(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        rem_fix  = neg_rem ? neg_w(acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
    end

    // Operand/accumulator datapath: no reset, only meaningful while RUN/FIX
    always_ff @(posedge clk) begin
        if (accept_arith) begin
            is_div  <= op[1];
            dz_pend <= op[1] && (rt_val == {WIDTH{1'b0}});
            neg_res <= signed_op && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
            neg_rem <= signed_op && rs_val[WIDTH-1];
            if (op[1]) begin
                acc <= {{WIDTH{1'b0}}, mag(rs_val, signed_op)};
                opb <= mag(rt_val, signed_op);
            end else begin
                acc <= {{WIDTH{1'b0}}, mag(rt_val, signed_op)};
                opb <= mag(rs_val, signed_op);
            end
        end else if (state == RUN) begin
            acc <= is_div ? div_next : mul_next;
        end
    end

    // Control FSM and architectural HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MTHI: hi <= rs_val;
                            OP_MTLO: lo <= rs_val;
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                state       <= RUN;
                                cnt         <= CNT_W'(WIDTH);
                                busy        <= 1'b1;
                                div_by_zero <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state <= FIX;
                end
                FIX: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    if (is_div && dz_pend) begin
                        div_by_zero <= 1'b1;
                    end else if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Parametrised multiply/divide unit owning the architectural HI/LO register pair. It executes MIPS MULT, MULTU, DIV, DIVU, MTHI and MTLO. Multiply and divide run iteratively, one bit per cycle, behind a start/busy/done handshake. It sits beside the ALU in EX: MFHI/MFLO read `hi`/`lo` directly, and the hazard unit stalls on `busy`.

## Interface
- `WIDTH`, 32: operand width and HI/LO width. Must be ≥ 4.
- `CNT_W`, $clog2(WIDTH)+1: width of the internal iteration counter.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the `clk` rising edge.
- `start`  in  1  request; accepted only on an edge where `busy`=0.
- `op`  in  3  operation select:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110/111 are no-ops: accepted, no state change, no `done`.
- `rs_val`  in  WIDTH  multiplicand / dividend / MTHI-MTLO source.
- `rt_val`  in  WIDTH  multiplier / divisor.
- `busy`  out  1  a multiply or divide is in progress.
- `done`  out  1  one-cycle pulse when HI/LO have just been written by MULT/MULTU/DIV/DIVU.
- `div_by_zero`  out  1  set by a DIV/DIVU with `rt_val`=0; cleared by the next accepted start.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States: IDLE, RUN, FIX.
- Reset values: state=IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_by_zero`=0, counter=0.
- Reset has priority over everything and aborts any operation in RUN or FIX.
- IDLE with `start`=1 and MTHI/MTLO: `hi` (resp. `lo`) ← `rs_val` on that edge. State stays IDLE; `busy` and `done` stay 0.
- IDLE with `start`=1 and MULT/MULTU/DIV/DIVU:
  - Latch operands and op; clear `div_by_zero`; go to RUN with counter=WIDTH.
  - Signed ops latch magnitudes (two's-complement absolute value) and record the result sign and dividend sign.
- RUN: one iteration per cycle, counter decrements; when the counter reaches 0, go to FIX.
  - Multiply: shift-add into a 2×WIDTH product accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
- FIX:
  - Multiply: apply sign to the 2×WIDTH product.
  - Divide: negate the quotient if operand signs differ; the remainder takes the dividend's sign.
  - Write `hi`/`lo`, pulse `done`, return to IDLE.
- Results:
  - Multiply: `hi`=product[2W-1:W], `lo`=product[W-1:0].
  - Divide: `lo`=quotient truncated toward zero, `hi`=remainder.
- `hi`/`lo` hold their old values throughout RUN; only FIX (or MTHI/MTLO) writes them.
- Divide by zero: full latency is still taken. In FIX, `hi`/`lo` are NOT written, `div_by_zero`←1, and `done` pulses.
- Signed overflow, DIV of −2^(W−1) by −1: `lo`=2^(W−1) pattern, `hi`=0; no flag.
- `start` while `busy`=1 is ignored: no queuing, no effect on the current operation.
- Operand inputs are don't-care after the accepting edge.

## Timing
- Accept edge E0 (`start`=1 and `busy`=0).
- `busy`=1 from after E0 through after edge E0+WIDTH. RUN lasts WIDTH cycles and FIX 1 cycle.
- `hi`/`lo` are updated and `done`=1 after edge E0+WIDTH+1, with `busy`=0 in the same cycle.
- Latency: WIDTH+1 cycles; 33 for WIDTH=32.
- Back-to-back: a new `start` may be accepted on the edge where `done` is high, i.e. the cycle after FIX, since `busy`=0 then.
- `done` lasts exactly one cycle.
- MTHI/MTLO: visible on `hi`/`lo` one edge after acceptance; zero stall.
- `busy`, `done`, `hi`, `lo` and `div_by_zero` are all registered outputs; there is no combinational input→output path.

## Test plan
All scenarios use WIDTH=32.
- MULT `rs`=0xFFFFFFFD (−3), `rt`=5 -> after 33 cycles `done`=1, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1; `busy` high for exactly 33 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001. MULT of the same operands -> `hi`=0, `lo`=1.
- DIV 0xFFFFFFF9 (−7) / 2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU 100 / 7 -> `lo`=14, `hi`=2.
- DIV 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- Preload MTHI 0x1234 then MTLO 0x5678, each visible one edge later; then DIVU x/0 -> `div_by_zero`=1, `done` pulses at cycle 33, `hi`=0x1234 and `lo`=0x5678 unchanged. A following MULTU clears `div_by_zero` on its accept edge.
- Start MULTU, pulse `start` with DIV at cycle 10 (ignored); assert `reset` at cycle 20 -> next edge `busy`=0, `hi`=`lo`=0, no `done` ever pulses. A MULTU 6×7 started after reset gives `lo`=42, `hi`=0 at 33 cycles.
